// File: rtl/if_id_queue_if.sv
// Handshake bundle between IF, the instruction queue and ID.
//   if_to_q_valid/if_to_q_zip/q_allowin : IF -> queue packet handshake
//   q_to_id_valid/q_to_id_zip/id_allowin : queue -> ID packet handshake
//   flush                                : branch taken in ID, discard contents
//   q_count                              : current queue occupancy
// master: the IF/ID pipeline side; slave: the queue itself.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ZIP_W = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             if_to_q_valid;
    logic             q_allowin;
    logic [ZIP_W-1:0] if_to_q_zip;
    logic             q_to_id_valid;
    logic             id_allowin;
    logic [ZIP_W-1:0] q_to_id_zip;
    logic             flush;
    logic [CNT_W-1:0] q_count;

    modport master (
        output if_to_q_valid,
        output if_to_q_zip,
        output id_allowin,
        output flush,
        input  q_allowin,
        input  q_to_id_valid,
        input  q_to_id_zip,
        input  q_count
    );

    modport slave (
        input  if_to_q_valid,
        input  if_to_q_zip,
        input  id_allowin,
        input  flush,
        output q_allowin,
        output q_to_id_valid,
        output q_to_id_zip,
        output q_count
    );
endinterface

// File: rtl/if_id_queue.sv
// Instruction queue between IF and ID: a DEPTH-entry circular buffer of
// {inst, pc} packets that decouples fetch from decode stalls.
//   clk    : clock, rising-edge state updates
//   resetn : asynchronous active-low reset (empties the queue)
//   q      : slave side of if_id_queue_if (IF push, ID pop, flush, count)
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// Handshake outputs depend only on registered state; there is no path from
// id_allowin or flush to q_allowin, and no same-cycle push-to-output bypass.
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ZIP_W = 64
) (
    input  logic          clk,
    input  logic          resetn,
    if_id_queue_if.slave  q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ZIP_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Occupancy flags and qualified handshakes; flush masks both sides.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == CNT_W'(0));
    assign w_push  = q.if_to_q_valid & ~w_full  & ~q.flush;
    assign w_pop   = q.id_allowin    & ~w_empty & ~q.flush;

    assign q.q_allowin     = ~w_full;
    assign q.q_to_id_valid = ~w_empty;
    assign q.q_to_id_zip   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign q.q_count       = r_count;

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= q.if_to_q_zip;
        end
    end

    // Pointers and occupancy; flush returns everything to the reset state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ZIP_W = 64;

    logic clk = 1'b0;
    logic resetn;

    if_id_queue_if #(.DEPTH(DEPTH), .ZIP_W(ZIP_W)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .ZIP_W(ZIP_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    string       phase  = "init";
    logic [63:0] mq [$];
    logic [31:0] pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    // Expected outputs follow purely from the model's occupancy and head.
    task automatic check_outs();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk("valid",   64'(bus.q_to_id_valid), 64'(mq.size() != 0));
        chk("allowin", 64'(bus.q_allowin),     64'(mq.size() != DEPTH));
        chk("count",   64'(bus.q_count),       64'(mq.size()));
        chk("zip",     bus.q_to_id_zip,        head);
    endtask

    // One clock cycle: drive at negedge, check before the edge, then advance the model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] p,
                        input logic a, input logic f);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        bus.if_to_q_valid = v;
        bus.if_to_q_zip   = {inst, p};
        bus.id_allowin    = a;
        bus.flush         = f;
        #1;
        check_outs();
        do_push = v && (mq.size() < DEPTH) && !f;
        do_pop  = (mq.size() != 0) && a && !f;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({inst, p});
        end
    endtask

    initial begin
        bus.if_to_q_valid = 1'b0;
        bus.if_to_q_zip   = '0;
        bus.id_allowin    = 1'b0;
        bus.flush         = 1'b0;
        resetn            = 1'b0;
        #12;
        phase = "reset";
        check_outs();
        resetn = 1'b1;

        // Fill to full with ID stalled, then one extra push attempt.
        phase = "fill";
        for (int i = 0; i < 4; i++) step(1'b1, 32'h02800400, 32'h1c000000 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h0badf00d, 32'h1c000010, 1'b0, 1'b0);

        // Full: a pop does not free a slot for a same-cycle push.
        phase = "full_pop";
        step(1'b1, 32'h0badf00d, 32'h1c000010, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Drain to one entry, then stream with both sides active.
        phase = "drain";
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        phase = "stream";
        pc = 32'h1c000010;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h00100000 + 32'(i), pc, 1'b1, 1'b0);
            pc = pc + 32'd4;
        end

        // Get to three entries, then flush with both handshakes active.
        phase = "flush";
        step(1'b1, 32'h11111111, 32'h1c000080, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 32'h1c000084, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 32'h1c000088, 1'b1, 1'b1);
        step(1'b1, 32'h44444444, 32'h1c000100, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty-queue push latency.
        phase = "latency";
        step(1'b1, 32'h02800400, 32'h1c000000, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("latency_zip", bus.q_to_id_zip, 64'h028004001c000000);

        // Asynchronous reset between edges with two entries held.
        phase = "async_reset";
        step(1'b1, 32'hdeadbeef, 32'h1c000004, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        bus.if_to_q_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        check_outs();
        @(negedge clk);
        resetn = 1'b1;
        phase = "after_reset";
        step(1'b1, 32'h0a0a0a0a, 32'h1c000200, 1'b0, 1'b0);
        step(1'b1, 32'h0b0b0b0b, 32'h1c000204, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the IF stage and the ID stage; decouples fetch from decode stalls.
- Accepts {inst, pc} packets from IF through a valid/allowin handshake and stores them in a circular buffer.
- Presents packets to ID in program order through the same handshake style.
- A branch flush discards every buffered packet, because all of them are on the wrong path.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- ZIP_W, 64, packet width: inst[63:32], pc[31:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- if_to_q_valid  input  1  IF presents a valid packet.
- q_allowin  output  1  queue can accept a packet this cycle (drives IF's id_allowin).
- if_to_q_zip  input  ZIP_W  packet from IF.
- q_to_id_valid  output  1  head packet is valid.
- id_allowin  input  1  ID accepts the head packet this cycle.
- q_to_id_zip  output  ZIP_W  head packet.
- flush  input  1  branch taken in ID; discard all contents.
- q_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: storage array mem[DEPTH], rd_ptr and wr_ptr of width $clog2(DEPTH), and count of width $clog2(DEPTH+1).
- Reset (resetn=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Outputs are then q_to_id_valid=0, q_allowin=1, q_count=0, q_to_id_zip=0. The storage array is not reset.
- push = if_to_q_valid & q_allowin & ~flush.
- pop = q_to_id_valid & id_allowin & ~flush.
- q_allowin = (count != DEPTH). It is registered-state only, with no combinational path from id_allowin or flush.
- q_to_id_valid = (count != 0).
- q_to_id_zip = mem[rd_ptr] when count != 0, otherwise 0.
- Push: mem[wr_ptr] <= if_to_q_zip; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together (including at count=1).
- Latency: a packet pushed in cycle N is visible at the output in cycle N+1. There is no same-cycle bypass.
- Full (count=DEPTH):
  - q_allowin=0, so IF holds its PC.
  - A pop in this cycle does not enable a push in the same cycle.
  - q_allowin rises in the next cycle.
- Empty (count=0): q_to_id_valid=0 and id_allowin is ignored.
- Flush (takes priority over push and pop):
  - Next cycle: rd_ptr=0, wr_ptr=0, count=0.
  - The same-cycle IF packet is dropped.
  - The same-cycle ID handshake is not counted as a pop; ID owns the squash of its own stage.
- Ordering: packets leave in exactly the order they entered; no duplication and no loss except on flush.
- Reset asserted mid-operation: the queue empties immediately and asynchronously. After release, the first push lands at mem[0].
- No X propagation on q_to_id_zip when empty.

Test Plan:
- Reset, then push pc=0x1c000000..0x1c00000c with id_allowin=0 → q_count goes 1,2,3,4; q_allowin=0 after the 4th push; q_to_id_valid=1 with zip pc=0x1c000000.
- Full queue, id_allowin=1 and if_to_q_valid=1 for one cycle → pop of pc 0x1c000000, no push, q_count=3; q_allowin=1 the next cycle.
- Streaming with both valids high for 10 cycles starting from count=1 → q_count stays 1; output pcs increment by 4 each cycle; pointers wrap past index 3 with no gaps.
- count=3 and flush=1 together with if_to_q_valid=1 and id_allowin=1 → next cycle q_count=0, q_to_id_valid=0, q_to_id_zip=0; the next push (pc=0x1c000100) appears at the output one cycle later.
- Empty queue, push inst=0x02800400 pc=0x1c000000 in cycle N → q_to_id_valid=0 in cycle N, =1 in N+1 with zip=0x028004001c000000.
- resetn pulled low between clock edges with count=2 → q_to_id_valid=0 and q_count=0 immediately, before the next edge; after release, pushes restart cleanly from mem[0].
